// File: rtl/vector_output_serializer.sv
// Vector result serializer: buffers flagged 96-bit CPU result vectors and streams them as 16-bit lanes.
// Optional lane parity output is enabled by defining VECTOR_OUT_PARITY_EN.
//
// state | meaning
// IDLE  | FIFO empty, laneValid low
// SEND  | presenting lane laneIndex of the head vector
module vector_output_serializer #(
  parameter int DATA_WIDTH  = 16,
  parameter int VECTOR_SIZE = 6,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              outFlag,
  input  logic [DATA_WIDTH*VECTOR_SIZE-1:0] out,
  output logic [DATA_WIDTH-1:0]             laneData,
  output logic                              laneValid,
  input  logic                              laneReady,
  output logic [2:0]                        laneIndex,
  output logic                              lastLane,
  output logic                              laneParity,
  output logic [$clog2(FIFO_DEPTH):0]       fifoCount,
  output logic                              overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]            state;
  logic [PW-1:0]         rdPtr;
  logic [PW-1:0]         wrPtr;
  logic [DATA_WIDTH-1:0] mem      [FIFO_DEPTH][VECTOR_SIZE];
  logic [DATA_WIDTH-1:0] outLanes [VECTOR_SIZE];

  logic          atLast;
  logic          handshake;
  logic          pop;
  logic          full;
  logic          push;
  logic          drop;
  logic [CW-1:0] countNext;

  for (genvar g = 0; g < VECTOR_SIZE; g++) begin : g_unpack
    assign outLanes[g] = out[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // A push is still accepted when full if the head leaves on the same edge.
  always_comb begin
    atLast    = (laneIndex == 3'(VECTOR_SIZE - 1));
    handshake = (state == SEND) && laneReady;
    pop       = handshake && atLast;
    full      = (fifoCount == CW'(FIFO_DEPTH));
    push      = outFlag && (!full || pop);
    drop      = outFlag && full && !pop;
    countNext = fifoCount;
    if (push && !pop) begin
      countNext = fifoCount + CW'(1);
    end else if (pop && !push) begin
      countNext = fifoCount - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wrPtr] <= outLanes;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      laneIndex <= '0;
      rdPtr     <= '0;
      wrPtr     <= '0;
      fifoCount <= '0;
      overflow  <= 1'b0;
    end else begin
      fifoCount <= countNext;
      if (push) begin
        wrPtr <= wrPtr + PW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PW'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      case (state)
        IDLE: begin
          laneIndex <= '0;
          if (fifoCount != '0) begin
            state <= SEND;
          end
        end
        SEND: begin
          if (handshake) begin
            if (atLast) begin
              laneIndex <= '0;
              if (countNext == '0) begin
                state <= IDLE;
              end
            end else begin
              laneIndex <= laneIndex + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Head entry is never overwritten while presented, so the lane holds under backpressure.
  assign laneValid = (state == SEND);
  assign laneData  = laneValid ? mem[rdPtr][laneIndex] : '0;
  assign lastLane  = laneValid && atLast;

`ifdef VECTOR_OUT_PARITY_EN
  assign laneParity = ^laneData;
`else
  assign laneParity = 1'b0;
`endif

endmodule

// File: tb/tb_vector_output_serializer.sv
// Self-checking bench for vector_output_serializer: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_vector_output_serializer;

  localparam int DW = 16;
  localparam int VS = 6;
  localparam int FD = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          outFlag = 1'b0;
  logic [95:0]   outVec = '0;
  logic          laneReady = 1'b0;
  logic [15:0]   laneData;
  logic          laneValid;
  logic [2:0]    laneIndex;
  logic          lastLane;
  logic          laneParity;
  logic [2:0]    fifoCount;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  vector_output_serializer #(.DATA_WIDTH(DW), .VECTOR_SIZE(VS), .FIFO_DEPTH(FD)) dut (
    .clock(clock), .reset(reset), .outFlag(outFlag), .out(outVec),
    .laneData(laneData), .laneValid(laneValid), .laneReady(laneReady),
    .laneIndex(laneIndex), .lastLane(lastLane), .laneParity(laneParity),
    .fifoCount(fifoCount), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic expPar(input logic [15:0] v);
`ifdef VECTOR_OUT_PARITY_EN
    return ^v;
`else
    return 1'b0 & v[0];
`endif
  endfunction

  function automatic logic [15:0] laneOf(input logic [95:0] v, input int k);
    return v[k*16 +: 16];
  endfunction

  // Reference model: queue of buffered vectors, current lane index, valid flag.
  logic [95:0] mq[$];
  logic [15:0] emitted[$];
  int          mIdx = 0;
  logic        mValid = 1'b0;
  logic        mOvf = 1'b0;
  logic        started = 1'b0;

  always @(posedge clock) begin
    logic hs, popNow, isFull, pushOk, dropNow;
    int   sizeAfter;
    if (!reset && laneValid && laneReady) emitted.push_back(laneData);
    started = 1'b1;
    if (reset) begin
      mq.delete();
      mIdx = 0;
      mValid = 1'b0;
      mOvf = 1'b0;
    end else begin
      hs        = mValid && laneReady;
      popNow    = hs && (mIdx == VS - 1);
      isFull    = (mq.size() == FD);
      pushOk    = outFlag && (!isFull || popNow);
      dropNow   = outFlag && isFull && !popNow;
      sizeAfter = mq.size() - (popNow ? 1 : 0) + (pushOk ? 1 : 0);
      if (mValid) begin
        if (popNow) begin
          mIdx = 0;
          mValid = (sizeAfter > 0);
        end else if (hs) begin
          mIdx++;
        end
      end else begin
        mValid = (mq.size() > 0);
      end
      if (popNow) void'(mq.pop_front());
      if (pushOk) mq.push_back(outVec);
      if (dropNow) mOvf = 1'b1;
    end
  end

  always @(negedge clock) begin
    logic [95:0] head;
    logic [15:0] lane;
    if (started) begin
      chk("m_valid", 96'(laneValid), 96'(mValid));
      chk("m_count", 96'(fifoCount), 96'(mq.size()));
      chk("m_overflow", 96'(overflow), 96'(mOvf));
      if (mValid && mq.size() > 0) begin
        head = mq[0];
        lane = laneOf(head, mIdx);
        chk("m_data", 96'(laneData), 96'(lane));
        chk("m_index", 96'(laneIndex), 96'(mIdx));
        chk("m_last", 96'(lastLane), 96'(mIdx == VS - 1));
        chk("m_parity", 96'(laneParity), 96'(expPar(lane)));
      end else begin
        chk("m_idle_data", 96'(laneData), 96'(0));
        chk("m_idle_index", 96'(laneIndex), 96'(0));
        chk("m_idle_last", 96'(lastLane), 96'(0));
        chk("m_idle_parity", 96'(laneParity), 96'(0));
      end
    end
  end

  task automatic tick(input logic f, input logic [95:0] v, input logic r);
    outFlag = f;
    outVec = v;
    laneReady = r;
    @(negedge clock);
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0);
    reset = 1'b0;
  endtask

  localparam logic [95:0] V1 = 96'h0006_0005_0004_0003_0002_0001;
  localparam logic [95:0] V2 = 96'h00AA_00BB_00CC_00DD_00EE_0007;

  logic [95:0] vecs[5];

  initial begin
    @(negedge clock);
    doReset();
    chk("rst_valid", 96'(laneValid), 96'(0));
    chk("rst_data", 96'(laneData), 96'(0));
    chk("rst_count", 96'(fifoCount), 96'(0));
    chk("rst_overflow", 96'(overflow), 96'(0));

    // Single vector with ready held high.
    tick(1'b1, V1, 1'b1);
    chk("cap_count", 96'(fifoCount), 96'(1));
    chk("cap_valid", 96'(laneValid), 96'(0));
    tick(1'b0, '0, 1'b1);
    chk("first_valid", 96'(laneValid), 96'(1));
    chk("first_data", 96'(laneData), 96'(1));
    for (int k = 1; k < VS; k++) begin
      tick(1'b0, '0, 1'b1);
      chk("seq_data", 96'(laneData), 96'(k + 1));
      chk("seq_last", 96'(lastLane), 96'(k == 5));
    end
    tick(1'b0, '0, 1'b1);
    chk("done_valid", 96'(laneValid), 96'(0));
    chk("done_count", 96'(fifoCount), 96'(0));

    // Backpressure while lane 2 is presented.
    tick(1'b1, V1, 1'b1);
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, '0, 1'b0);
      chk("bp_data", 96'(laneData), 96'(3));
      chk("bp_index", 96'(laneIndex), 96'(2));
      chk("bp_parity", 96'(laneParity), 96'(0));
    end
    tick(1'b0, '0, 1'b1);
    chk("bp_resume", 96'(laneData), 96'(4));
    for (int k = 0; k < 4; k++) tick(1'b0, '0, 1'b1);
    chk("bp_done", 96'(laneValid), 96'(0));

    // Overflow: five flagged vectors with no consumer.
    doReset();
    for (int i = 0; i < 5; i++) vecs[i] = {16'(i*16+6), 16'(i*16+5), 16'(i*16+4), 16'(i*16+3), 16'(i*16+2), 16'(i*16+1)} | 96'h1000_1000_1000_1000_1000_1000;
    for (int i = 0; i < 5; i++) tick(1'b1, vecs[i], 1'b0);
    chk("ovf_count", 96'(fifoCount), 96'(4));
    chk("ovf_flag", 96'(overflow), 96'(1));
    emitted.delete();
    for (int k = 0; k < 26; k++) tick(1'b0, '0, 1'b1);
    chk("ovf_drained", 96'(emitted.size()), 96'(24));
    if (emitted.size() == 24)
      for (int i = 0; i < 24; i++) chk("ovf_order", 96'(emitted[i]), 96'(laneOf(vecs[i/6], i%6)));
    chk("ovf_sticky", 96'(overflow), 96'(1));

    // Push on full coinciding with the last-lane pop.
    doReset();
    for (int i = 0; i < 4; i++) tick(1'b1, vecs[i], 1'b0);
    emitted.delete();
    for (int k = 0; k < 5; k++) tick(1'b0, '0, 1'b1);
    chk("pf_last", 96'(lastLane), 96'(1));
    tick(1'b1, vecs[4], 1'b1);
    chk("pf_count", 96'(fifoCount), 96'(4));
    chk("pf_overflow", 96'(overflow), 96'(0));
    for (int k = 0; k < 26; k++) tick(1'b0, '0, 1'b1);
    chk("pf_total", 96'(emitted.size()), 96'(30));
    if (emitted.size() == 30)
      for (int k = 0; k < 6; k++) chk("pf_tail", 96'(emitted[24+k]), 96'(laneOf(vecs[4], k)));

    // Reset after the lane 3 handshake.
    doReset();
    tick(1'b1, V1, 1'b1);
    for (int k = 0; k < 5; k++) tick(1'b0, '0, 1'b1);
    chk("mid_data", 96'(laneData), 96'(5));
    reset = 1'b1;
    tick(1'b0, '0, 1'b1);
    chk("mr_valid", 96'(laneValid), 96'(0));
    chk("mr_data", 96'(laneData), 96'(0));
    chk("mr_index", 96'(laneIndex), 96'(0));
    chk("mr_last", 96'(lastLane), 96'(0));
    chk("mr_count", 96'(fifoCount), 96'(0));
    reset = 1'b0;
    tick(1'b1, V2, 1'b1);
    tick(1'b0, '0, 1'b0);
    chk("mr_new_index", 96'(laneIndex), 96'(0));
    chk("mr_new_data", 96'(laneData), 96'(16'h0007));
`ifdef VECTOR_OUT_PARITY_EN
    chk("par_7", 96'(laneParity), 96'(1));
`else
    chk("par_off", 96'(laneParity), 96'(0));
`endif
    for (int k = 0; k < 8; k++) tick(1'b0, '0, 1'b1);

    // Back-to-back vectors.
    doReset();
    emitted.delete();
    tick(1'b1, V2, 1'b1);
    tick(1'b1, V1, 1'b1);
    for (int k = 0; k < 14; k++) tick(1'b0, '0, 1'b1);
    chk("b2b_total", 96'(emitted.size()), 96'(12));
    if (emitted.size() == 12) begin
      chk("b2b_first", 96'(emitted[0]), 96'(16'h0007));
      chk("b2b_second", 96'(emitted[6]), 96'(1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_output_serializer.md
# vector_output_serializer

Sink for the CPU's vector result port. Captures every 96-bit `out` word the CPU flags with `outFlag`, buffers it in a small FIFO, and streams it out one 16-bit lane at a time over a valid/ready handshake. It sits between the CPU top level and a narrow external consumer such as a host link or display driver. It replaces the bench-only file dump as the hardware path for results.

## Interface
- `DATA_WIDTH`, 16, lane width in bits
- `VECTOR_SIZE`, 6, lanes per captured vector
- `FIFO_DEPTH`, 4, vectors buffered; power of two, ≥2
- `clock`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `outFlag`  in  1  CPU result strobe; capture request this cycle
- `out`  in  DATA_WIDTH*VECTOR_SIZE  CPU result vector; lane k = bits [16k+15:16k]
- `laneData`  out  DATA_WIDTH  current lane of head vector
- `laneValid`  out  1  laneData/laneIndex/lastLane valid
- `laneReady`  in  1  consumer accepts lane when high with laneValid
- `laneIndex`  out  3  lane number 0..VECTOR_SIZE-1
- `lastLane`  out  1  high when laneIndex == VECTOR_SIZE-1 and laneValid
- `laneParity`  out  1  even parity of laneData (see Configuration)
- `fifoCount`  out  $clog2(FIFO_DEPTH)+1  vectors held, including one in transfer
- `overflow`  out  1  sticky: a flagged vector was dropped

## Operation
- Push: `outFlag`=1 and FIFO not full → `out` written at tail, count+1.
- Full, no pop this cycle: vector dropped, `overflow` set; cleared only by reset. CPU is never stalled.
- Pop: handshake (`laneValid && laneReady`) on lane VECTOR_SIZE-1 removes head.
- Push and pop same cycle: both happen, count unchanged; accepted even when full.
- FSM states: IDLE, SEND.
  - IDLE: `laneValid`=0. If count>0 → SEND, laneIndex=0.
  - SEND: `laneValid`=1, `laneData` = head lane `laneIndex`. Handshake on lane < last → laneIndex+1. Handshake on last lane → pop, laneIndex=0; stay SEND if count after pop >0, else IDLE.
- While `laneValid && !laneReady`: laneData, laneIndex, lastLane, laneParity held stable.
- Pointers wrap modulo FIFO_DEPTH. Full when count==FIFO_DEPTH, empty when count==0.
- Reset (any time, including mid-vector): FIFO emptied, state IDLE, laneIndex 0, overflow 0. Partially sent vector discarded, no completion.

## Timing
- All outputs reset to 0.
- Capture edge N (outFlag high into empty FIFO) → fifoCount=1 after N; FSM enters SEND at edge N+1; first `laneValid` high in cycle after N+1.
- With `laneReady` held high: one lane per cycle, VECTOR_SIZE cycles per vector. Back-to-back vectors have no idle cycle between last lane of one and lane 0 of next.
- `fifoCount` decrements the cycle after the last-lane handshake.
- `overflow` rises the cycle after the dropping edge.

## Configuration
- `VECTOR_OUT_PARITY_EN` defined: `laneParity` = XOR-reduce of `laneData`, registered with it, valid under same rules.
- Undefined: `laneParity` tied 0, no parity logic.

## Test plan
- Single vector: out=0x0006_0005_0004_0003_0002_0001, outFlag 1 cycle, laneReady=1 → laneData 1,2,3,4,5,6 on consecutive cycles, lastLane only on 6, fifoCount 1→0, then IDLE.
- Backpressure: laneReady=0 for 3 cycles during lane 2 → laneData=3, laneIndex=2 held stable; resumes with lane 3 after ready.
- Overflow: laneReady=0, 5 flagged vectors with FIFO_DEPTH=4 → fifoCount=4, overflow=1, 5th vector never appears. Draining yields the first 4 in order.
- Push on full with pop: FIFO full, outFlag coincides with last-lane handshake → fifoCount stays 4, overflow stays 0, new vector is emitted last.
- Reset mid-vector: reset asserted after lane 3 handshake → next cycle all outputs 0, fifoCount 0. New vector after reset starts at lane 0.
- Parity (macro defined): lane 0x0007 → laneParity=1; lane 0x0003 → 0. Macro undefined → always 0.
